// File: rtl/stream_arb_pkg.sv
// Shared types for the weighted round-robin stream arbiter.
package stream_arb_pkg;

   // Default width of one weight field; a burst holds at most 2**W-1 beats.
   localparam int unsigned W_WIDTH_DEFAULT = 4;

   // Arbiter control state: searching for a requester, or holding a grant.
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   // Weight / credit field at the default width.
   typedef logic [W_WIDTH_DEFAULT-1:0] weight_t;

endpackage : stream_arb_pkg

// File: rtl/stream_mux.sv
// Zero-latency valid/ready stream multiplexer: routes the selected input
// stream to the output and returns ready to the selected input only.
module stream_mux #(
   parameter type         DATA_T    = logic,
   parameter int unsigned N_INP     = 2,
   parameter int unsigned LOG_N_INP = (N_INP > 1) ? $clog2(N_INP) : 1
) (
   input  DATA_T                inp_data_i  [N_INP],
   input  logic [N_INP-1:0]     inp_valid_i,
   output logic [N_INP-1:0]     inp_ready_o,
   input  logic [LOG_N_INP-1:0] inp_sel_i,
   output DATA_T                oup_data_o,
   output logic                 oup_valid_o,
   input  logic                 oup_ready_i
);

   // Purely combinational select; an out-of-range select drives an idle output.
   always_comb begin
      inp_ready_o = '0;
      oup_data_o  = '0;
      oup_valid_o = 1'b0;
      for (int i = 0; i < int'(N_INP); i++) begin
         if (inp_sel_i == LOG_N_INP'(i)) begin
            oup_data_o     = inp_data_i[i];
            oup_valid_o    = inp_valid_i[i];
            inp_ready_o[i] = oup_ready_i;
         end
      end
   end

endmodule : stream_mux

// File: rtl/stream_wrr_arbiter.sv
// Weighted round-robin arbiter in front of a stream_mux. A requester keeps
// the grant for up to its weight in beats, then the grant rotates onward.
module stream_wrr_arbiter
   import stream_arb_pkg::*;
#(
   parameter type         DATA_T    = logic,
   parameter int unsigned N_INP     = 2,
   parameter int unsigned W_WIDTH   = $bits(weight_t),
   parameter int unsigned LOG_N_INP = $clog2(N_INP)
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            flush_i,
   input  logic [N_INP-1:0][W_WIDTH-1:0]   weight_i,
   input  DATA_T                           inp_data_i  [N_INP],
   input  logic [N_INP-1:0]                inp_valid_i,
   output logic [N_INP-1:0]                inp_ready_o,
   output DATA_T                           oup_data_o,
   output logic                            oup_valid_o,
   input  logic                            oup_ready_i,
   output logic [LOG_N_INP-1:0]            sel_o,
   output logic                            locked_o
);

   state_e               state_q, state_d;
   logic [LOG_N_INP-1:0] rr_ptr_q, rr_ptr_d;
   logic [LOG_N_INP-1:0] sel_q, sel_d;
   logic [W_WIDTH-1:0]   credit_q, credit_d;

   logic [LOG_N_INP-1:0] sel_search;
   logic                 found;
   logic [W_WIDTH-1:0]   weight_raw;
   logic [W_WIDTH-1:0]   weight_eff;
   logic                 beat;

   // Pointer increment with wrap at N_INP-1 (N_INP need not be a power of two).
   function automatic logic [LOG_N_INP-1:0] ptr_inc(input logic [LOG_N_INP-1:0] p);
      if (int'(p) == int'(N_INP) - 1) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // Rotated leading-one detector: first valid requester at or after rr_ptr.
   // Scanning from the far end lets the nearest hit overwrite earlier ones.
   always_comb begin
      int idx;
      sel_search = rr_ptr_q;
      found      = 1'b0;
      idx        = 0;
      for (int k = int'(N_INP) - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= int'(N_INP)) begin
            idx = idx - int'(N_INP);
         end
         if (inp_valid_i[idx]) begin
            sel_search = LOG_N_INP'(idx);
            found      = 1'b1;
         end
      end
   end

   // A weight of zero still grants one beat.
   always_comb begin
      weight_raw = weight_i[sel_search];
      weight_eff = (weight_raw == '0) ? W_WIDTH'(1) : weight_raw;
   end

   // While locked the selection is frozen; otherwise follow the live search.
   assign sel_o    = (state_q == LOCKED) ? sel_q : sel_search;
   assign locked_o = (state_q == LOCKED);
   assign beat     = oup_valid_o & oup_ready_i;

   stream_mux #(
      .DATA_T    (DATA_T),
      .N_INP     (N_INP),
      .LOG_N_INP (LOG_N_INP)
   ) i_stream_mux (
      .inp_data_i  (inp_data_i),
      .inp_valid_i (inp_valid_i),
      .inp_ready_o (inp_ready_o),
      .inp_sel_i   (sel_o),
      .oup_data_o  (oup_data_o),
      .oup_valid_o (oup_valid_o),
      .oup_ready_i (oup_ready_i)
   );

   // Next-state logic: grant entry, credit countdown, release and flush.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      sel_d    = sel_q;
      credit_d = credit_q;

      case (state_q)
         IDLE: begin
            if (found) begin
               if (beat) begin
                  if (weight_eff == W_WIDTH'(1)) begin
                     // Single-beat grant completes in place; move on.
                     rr_ptr_d = ptr_inc(sel_search);
                  end else begin
                     state_d  = LOCKED;
                     sel_d    = sel_search;
                     credit_d = weight_eff - W_WIDTH'(1);
                  end
               end else begin
                  // Valid shown without a beat: hold this selection until it lands.
                  state_d  = LOCKED;
                  sel_d    = sel_search;
                  credit_d = weight_eff;
               end
            end
         end

         LOCKED: begin
            if (beat) begin
               if (credit_q <= W_WIDTH'(1)) begin
                  state_d  = IDLE;
                  rr_ptr_d = ptr_inc(sel_q);
                  credit_d = '0;
               end else begin
                  credit_d = credit_q - W_WIDTH'(1);
               end
            end else if (!inp_valid_i[sel_q]) begin
               // Requester went away mid-burst: remaining credit is forfeited.
               state_d  = IDLE;
               rr_ptr_d = ptr_inc(sel_q);
               credit_d = '0;
            end
         end

         default: begin
            state_d  = IDLE;
            credit_d = '0;
         end
      endcase

      if (flush_i) begin
         state_d  = IDLE;
         rr_ptr_d = '0;
         credit_d = '0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         sel_q    <= '0;
         credit_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         sel_q    <= sel_d;
         credit_q <= credit_d;
      end
   end

`ifndef SYNTHESIS
   a_n_inp_min : assert property (@(posedge clk_i) N_INP >= 2)
      else $error("stream_wrr_arbiter: N_INP must be >= 2");

   a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(inp_ready_o))
      else $error("stream_wrr_arbiter: more than one inp_ready_o bit set");

   a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (locked_o && oup_valid_o && !oup_ready_i && !flush_i)
         |=> ($stable(oup_data_o) && $stable(sel_o)))
      else $error("stream_wrr_arbiter: output changed while stalled");
`endif

endmodule : stream_wrr_arbiter

// File: tb/tb_stream_wrr_arbiter.sv
// Directed testbench for stream_wrr_arbiter (N_INP=4, 8-bit payloads).
module tb_stream_wrr_arbiter;

   localparam int N = 4;
   localparam int W = 4;
   typedef logic [7:0] data_t;

   logic                clk_i = 1'b0;
   logic                rst_ni;
   logic                flush_i;
   logic [N-1:0][W-1:0] weight_i;
   data_t               inp_data_i [N];
   logic [N-1:0]        inp_valid_i;
   logic [N-1:0]        inp_ready_o;
   data_t               oup_data_o;
   logic                oup_valid_o;
   logic                oup_ready_i;
   logic [1:0]          sel_o;
   logic                locked_o;

   int n_vec = 0;
   int n_err = 0;

   // Weighted pattern for weights {3,1,2,0}.
   int wt_sel [8] = '{0, 0, 0, 1, 2, 2, 3, 0};
   int wt_lck [8] = '{0, 1, 1, 0, 0, 1, 0, 0};

   always #5 clk_i = ~clk_i;

   stream_wrr_arbiter #(
      .DATA_T  (data_t),
      .N_INP   (N),
      .W_WIDTH (W)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .weight_i    (weight_i),
      .inp_data_i  (inp_data_i),
      .inp_valid_i (inp_valid_i),
      .inp_ready_o (inp_ready_o),
      .oup_data_o  (oup_data_o),
      .oup_valid_o (oup_valid_o),
      .oup_ready_i (oup_ready_i),
      .sel_o       (sel_o),
      .locked_o    (locked_o)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   // Check one cycle's combinational outputs mid-cycle, then advance.
   task automatic check_cycle(input string tag, input int exp_sel, input int exp_lck, input int exp_vld);
      logic [31:0] exp_rdy;
      #2;
      exp_rdy = oup_ready_i ? (32'd1 << exp_sel) : 32'd0;
      check_val({tag, "_sel"},    32'(sel_o),       32'(exp_sel));
      check_val({tag, "_locked"}, 32'(locked_o),    32'(exp_lck));
      check_val({tag, "_valid"},  32'(oup_valid_o), 32'(exp_vld));
      check_val({tag, "_data"},   32'(oup_data_o),  32'(8'hA0 + exp_sel));
      check_val({tag, "_ready"},  32'(inp_ready_o), exp_rdy);
      next_cycle();
   endtask

   task automatic do_flush();
      inp_valid_i = '0;
      flush_i     = 1'b1;
      next_cycle();
      flush_i     = 1'b0;
   endtask

   initial begin
      rst_ni      = 1'b0;
      flush_i     = 1'b0;
      oup_ready_i = 1'b0;
      inp_valid_i = '0;
      weight_i    = '0;
      for (int i = 0; i < N; i++) inp_data_i[i] = '0;

      // Reset and idle after release
      repeat (3) @(posedge clk_i);
      #3;
      check_val("rst_locked", 32'(locked_o), 32'd0);
      check_val("rst_valid",  32'(oup_valid_o), 32'd0);
      rst_ni = 1'b1;
      next_cycle();
      #2;
      check_val("idle_valid",  32'(oup_valid_o), 32'd0);
      check_val("idle_ready",  32'(inp_ready_o), 32'd0);
      check_val("idle_sel",    32'(sel_o),       32'd0);
      check_val("idle_locked", 32'(locked_o),    32'd0);
      check_val("idle_data",   32'(oup_data_o),  32'd0);

      for (int i = 0; i < N; i++) inp_data_i[i] = data_t'(8'hA0 + i);

      // Plain round robin, all weights 1
      for (int i = 0; i < N; i++) weight_i[i] = 4'd1;
      inp_valid_i = 4'hF;
      oup_ready_i = 1'b1;
      for (int c = 0; c < 8; c++) check_cycle($sformatf("rr%0d", c), c % 4, 0, 1);

      // Weighted: {3,1,2,0}
      weight_i[0] = 4'd3;
      weight_i[1] = 4'd1;
      weight_i[2] = 4'd2;
      weight_i[3] = 4'd0;
      for (int c = 0; c < 8; c++) check_cycle($sformatf("wt%0d", c), wt_sel[c], wt_lck[c], 1);
      do_flush();

      // Backpressure lock on input 2
      for (int i = 0; i < N; i++) weight_i[i] = 4'd1;
      inp_valid_i = 4'b0100;
      oup_ready_i = 1'b0;
      check_cycle("bp_enter", 2, 0, 1);
      for (int c = 0; c < 5; c++) check_cycle($sformatf("bp_hold%0d", c), 2, 1, 1);
      oup_ready_i = 1'b1;
      check_cycle("bp_beat", 2, 1, 1);
      inp_valid_i = '0;
      check_cycle("bp_rrptr", 3, 0, 0);

      // Early release of input 1 after 2 of 4 beats
      weight_i[1] = 4'd4;
      inp_valid_i = 4'b0010;
      check_cycle("er_b0", 1, 0, 1);
      check_cycle("er_b1", 1, 1, 1);
      inp_valid_i = 4'b0001;
      check_cycle("er_drop", 1, 1, 0);
      check_cycle("er_next", 0, 0, 1);
      do_flush();

      // Flush mid-burst on input 0 (weight 8), others requesting too
      weight_i[0] = 4'd8;
      inp_valid_i = 4'hF;
      check_cycle("fl_b0", 0, 0, 1);
      check_cycle("fl_b1", 0, 1, 1);
      check_cycle("fl_b2", 0, 1, 1);
      flush_i = 1'b1;
      check_cycle("fl_flush", 0, 1, 1);
      flush_i = 1'b0;
      check_cycle("fl_after", 0, 0, 1);

      // Reset mid-burst
      check_cycle("rs_b1", 0, 1, 1);
      check_cycle("rs_b2", 0, 1, 1);
      rst_ni      = 1'b0;
      inp_valid_i = '0;
      oup_ready_i = 1'b0;
      #1;
      check_val("rs_locked", 32'(locked_o),    32'd0);
      check_val("rs_valid",  32'(oup_valid_o), 32'd0);
      check_val("rs_ready",  32'(inp_ready_o), 32'd0);
      check_val("rs_sel",    32'(sel_o),       32'd0);
      next_cycle();
      rst_ni      = 1'b1;
      inp_valid_i = 4'b0100;
      oup_ready_i = 1'b1;
      check_cycle("post_rst", 2, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_stream_wrr_arbiter
